// File: rtl/dm_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter_if
//   Bundles the two requester ports, the data-memory control bus and the
//   status outputs of dm_port_arbiter.
//
//   Handshake: a requester raises pX_req together with pX_wr/pX_addr/pX_din
//   and holds all of them stable until it sees pX_gnt. pX_gnt is a one-cycle
//   pulse meaning "accepted and executing on the DM this cycle". For reads,
//   pX_rvalid pulses one cycle after pX_gnt with the data on pX_rdata.
//   In the cycle after pX_gnt the requester either drops pX_req or presents
//   a new transaction.
//
//   Modports:
//     slave  - the arbiter: consumes requests and mem_dout, drives grants,
//              read data, the DM control bus and status.
//     master - the environment: requesters plus the data memory.
// -----------------------------------------------------------------------------
interface dm_port_arbiter_if #(
   parameter int AWL = 32,
   parameter int DWL = 32
);
   // port 0 (pipeline MEM stage)
   logic           p0_req;
   logic           p0_wr;
   logic [AWL-1:0] p0_addr;
   logic [DWL-1:0] p0_din;
   logic           p0_gnt;
   logic [DWL-1:0] p0_rdata;
   logic           p0_rvalid;
   // port 1 (loader / debug DMA)
   logic           p1_req;
   logic           p1_wr;
   logic [AWL-1:0] p1_addr;
   logic [DWL-1:0] p1_din;
   logic           p1_gnt;
   logic [DWL-1:0] p1_rdata;
   logic           p1_rvalid;
   // data memory
   logic           mem_wr;
   logic [AWL-1:0] mem_addr;
   logic [DWL-1:0] mem_din;
   logic [DWL-1:0] mem_dout;
   // status
   logic           err_oob;
   logic           busy;
   logic           dbg_state;  // 0 = IDLE, 1 = SERVE

   modport slave (
      input  p0_req, p0_wr, p0_addr, p0_din,
      input  p1_req, p1_wr, p1_addr, p1_din,
      input  mem_dout,
      output p0_gnt, p0_rdata, p0_rvalid,
      output p1_gnt, p1_rdata, p1_rvalid,
      output mem_wr, mem_addr, mem_din,
      output err_oob, busy, dbg_state
   );

   modport master (
      output p0_req, p0_wr, p0_addr, p0_din,
      output p1_req, p1_wr, p1_addr, p1_din,
      output mem_dout,
      input  p0_gnt, p0_rdata, p0_rvalid,
      input  p1_gnt, p1_rdata, p1_rvalid,
      input  mem_wr, mem_addr, mem_din,
      input  err_oob, busy, dbg_state
   );
endinterface

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//   Two-requester round-robin arbiter and sequencer for the single-port data
//   memory. Port 0 is the pipeline MEM stage, port 1 the loader/debug port.
//   Each transaction takes an IDLE cycle (arbitrate + latch) followed by a
//   SERVE cycle (one DM access), so peak throughput is one access per two
//   cycles.
//
//   Ports:
//     CLK    - clock, rising edge
//     RST_N  - asynchronous active-low reset
//     bus    - dm_port_arbiter_if.slave: requests/grants/read data for both
//              ports, DM control (mem_wr/mem_addr/mem_din, mem_dout back),
//              err_oob pulse, busy and dbg_state.
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
   parameter int AWL   = 32,
   parameter int DWL   = 32,
   parameter int DEPTH = 32
) (
   input logic               CLK,
   input logic               RST_N,
   dm_port_arbiter_if.slave  bus
);

   typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_e;

   state_e         state_q, state_d;
   logic           last_q;      // port that won the most recent arbitration
   logic           owner_q;     // port owning the transaction in SERVE
   logic           wr_l_q;
   logic [AWL-1:0] addr_l_q;
   logic [DWL-1:0] din_l_q;
   logic           oob_l_q;
   logic [DWL-1:0] p0_rdata_q, p1_rdata_q;
   logic           p0_rvalid_q, p1_rvalid_q;

   logic           latch_en;
   logic           win;
   logic           sel_wr;
   logic [AWL-1:0] sel_addr;
   logic [DWL-1:0] sel_din;
   logic           serve;

   // Winner: a lone requester wins; on a tie the port that did not win last.
   assign win      = (bus.p0_req && bus.p1_req) ? ~last_q : bus.p1_req;
   assign sel_wr   = win ? bus.p1_wr   : bus.p0_wr;
   assign sel_addr = win ? bus.p1_addr : bus.p0_addr;
   assign sel_din  = win ? bus.p1_din  : bus.p0_din;

   // ---------------------------------------------------------------------------
   // State register and latched transaction fields
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;   // port 0 wins the first tie
         owner_q     <= 1'b0;
         wr_l_q      <= 1'b0;
         addr_l_q    <= '0;
         din_l_q     <= '0;
         oob_l_q     <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;

         if (latch_en) begin
            owner_q  <= win;
            last_q   <= win;
            wr_l_q   <= sel_wr;
            addr_l_q <= sel_addr;
            din_l_q  <= sel_din;
            // Full-width compare: high address bits never alias into the array.
            oob_l_q  <= (sel_addr >= AWL'(DEPTH));
         end

         // Read completes at the SERVE->IDLE edge; OOB reads return zero.
         if (state_q == SERVE && !wr_l_q) begin
            if (owner_q) begin
               p1_rdata_q  <= oob_l_q ? '0 : bus.mem_dout;
               p1_rvalid_q <= 1'b1;
            end else begin
               p0_rdata_q  <= oob_l_q ? '0 : bus.mem_dout;
               p0_rvalid_q <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic. Requests are ignored in SERVE, so a request still held
   // in the cycle of its own grant is never granted twice.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.p0_req || bus.p1_req) begin
               state_d  = SERVE;
               latch_en = 1'b1;
            end
         end
         SERVE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs, decoded from registered state only
   // ---------------------------------------------------------------------------
   assign serve = (state_q == SERVE);

   always_comb begin
      bus.p0_gnt    = serve & ~owner_q;
      bus.p1_gnt    = serve &  owner_q;
      // Dropped by reset instantly since state_q clears asynchronously.
      bus.mem_wr    = serve & wr_l_q & ~oob_l_q;
      bus.mem_addr  = addr_l_q;
      bus.mem_din   = din_l_q;
      bus.err_oob   = serve & oob_l_q;
      bus.busy      = serve;
      bus.dbg_state = state_q;
      bus.p0_rdata  = p0_rdata_q;
      bus.p1_rdata  = p1_rdata_q;
      bus.p0_rvalid = p0_rvalid_q;
      bus.p1_rvalid = p1_rvalid_q;
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
//   Directed bench for dm_port_arbiter: a cycle table of inputs and
//   hand-computed outputs, plus hand-written reset sequences. A small word
//   memory model sits on the DM bus.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;

   localparam int AWL   = 32;
   localparam int DWL   = 32;
   localparam int DEPTH = 32;

   // ---------------- clock / reset ----------------
   logic CLK;
   logic RST_N;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   dm_port_arbiter_if #(.AWL(AWL), .DWL(DWL)) bus ();

   dm_port_arbiter #(.AWL(AWL), .DWL(DWL), .DEPTH(DEPTH)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   // ---------------- data memory model ----------------
   logic [DWL-1:0] dm [0:DEPTH-1];
   logic           dm_init;

   // Out-of-range reads return a poison word so the arbiter's zeroing shows.
   assign bus.mem_dout = (bus.mem_addr < AWL'(DEPTH)) ? dm[bus.mem_addr[4:0]] : 32'hBAD0_BAD0;

   always @(posedge CLK) begin
      if (dm_init !== 1'b1) begin
         for (int i = 0; i < DEPTH; i++) dm[i] <= '0;
         dm[5]  <= 32'h0000_0055;
         dm[15] <= 32'd17;
         dm[16] <= 32'd31;
         dm[31] <= 32'h3131_3131;
         dm_init <= 1'b1;
      end else if (bus.mem_wr && bus.mem_addr < AWL'(DEPTH)) begin
         dm[bus.mem_addr[4:0]] <= bus.mem_din;
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        p0_req, p0_wr;
      logic [31:0] p0_addr, p0_din;
      logic        p1_req, p1_wr;
      logic [31:0] p1_addr, p1_din;
      logic        e_p0_gnt, e_p1_gnt, e_p0_rv, e_p1_rv;
      logic [31:0] e_p0_rd, e_p1_rd;
      logic        e_mem_wr, e_oob, e_busy;
      logic [31:0] e_mem_addr;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input int unsigned r0, w0, a0, d0,
      input int unsigned r1, w1, a1, d1,
      input int unsigned g0, g1, v0, v1,
      input int unsigned rd0, rd1,
      input int unsigned mw, oob, bsy, ma);
      vec_t v;
      v.p0_req = (r0 != 0);  v.p0_wr = (w0 != 0);  v.p0_addr = a0;  v.p0_din = d0;
      v.p1_req = (r1 != 0);  v.p1_wr = (w1 != 0);  v.p1_addr = a1;  v.p1_din = d1;
      v.e_p0_gnt = (g0 != 0);  v.e_p1_gnt = (g1 != 0);
      v.e_p0_rv  = (v0 != 0);  v.e_p1_rv  = (v1 != 0);
      v.e_p0_rd  = rd0;        v.e_p1_rd  = rd1;
      v.e_mem_wr = (mw != 0);  v.e_oob = (oob != 0);  v.e_busy = (bsy != 0);
      v.e_mem_addr = ma;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input vec_t v);
      bus.p0_req = v.p0_req;  bus.p0_wr = v.p0_wr;  bus.p0_addr = v.p0_addr;  bus.p0_din = v.p0_din;
      bus.p1_req = v.p1_req;  bus.p1_wr = v.p1_wr;  bus.p1_addr = v.p1_addr;  bus.p1_din = v.p1_din;
   endtask

   task automatic idle_inputs();
      bus.p0_req = 1'b0;  bus.p0_wr = 1'b0;  bus.p0_addr = '0;  bus.p0_din = '0;
      bus.p1_req = 1'b0;  bus.p1_wr = 1'b0;  bus.p1_addr = '0;  bus.p1_din = '0;
   endtask

   task automatic check_outputs(input string tag, input vec_t v);
      check({tag, " p0_gnt"},    32'(bus.p0_gnt),    32'(v.e_p0_gnt));
      check({tag, " p1_gnt"},    32'(bus.p1_gnt),    32'(v.e_p1_gnt));
      check({tag, " p0_rvalid"}, 32'(bus.p0_rvalid), 32'(v.e_p0_rv));
      check({tag, " p1_rvalid"}, 32'(bus.p1_rvalid), 32'(v.e_p1_rv));
      check({tag, " p0_rdata"},  bus.p0_rdata,       v.e_p0_rd);
      check({tag, " p1_rdata"},  bus.p1_rdata,       v.e_p1_rd);
      check({tag, " mem_wr"},    32'(bus.mem_wr),    32'(v.e_mem_wr));
      check({tag, " err_oob"},   32'(bus.err_oob),   32'(v.e_oob));
      check({tag, " busy"},      32'(bus.busy),      32'(v.e_busy));
      check({tag, " mem_addr"},  bus.mem_addr,       v.e_mem_addr);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      //                 p0: req wr addr din         p1: req wr addr din          g0 g1 v0 v1  rd0  rd1        mw oob bsy maddr
      vecs[0]  = mk(1,0,16,0,                 1,0,16,0,                   1,0,0,0, 0,0,                 0,0,1, 16);
      vecs[1]  = mk(1,0,16,0,                 1,0,16,0,                   0,0,1,0, 31,0,                0,0,0, 16);
      vecs[2]  = mk(1,0,16,0,                 1,0,16,0,                   0,1,0,0, 31,0,                0,0,1, 16);
      vecs[3]  = mk(1,0,16,0,                 1,0,16,0,                   0,0,0,1, 31,31,               0,0,0, 16);
      vecs[4]  = mk(1,0,16,0,                 1,0,16,0,                   1,0,0,0, 31,31,               0,0,1, 16);
      vecs[5]  = mk(1,0,16,0,                 1,0,16,0,                   0,0,1,0, 31,31,               0,0,0, 16);
      vecs[6]  = mk(1,0,16,0,                 1,0,16,0,                   0,1,0,0, 31,31,               0,0,1, 16);
      vecs[7]  = mk(0,0,0,0,                  0,0,0,0,                    0,0,0,1, 31,31,               0,0,0, 16);
      // single read of DM[15]
      vecs[8]  = mk(1,0,15,0,                 0,0,0,0,                    1,0,0,0, 31,31,               0,0,1, 15);
      vecs[9]  = mk(0,0,0,0,                  0,0,0,0,                    0,0,1,0, 17,31,               0,0,0, 15);
      // p1 writes addr 3, then p0 reads it back
      vecs[10] = mk(0,0,0,0,                  1,1,3,32'hDEADBEEF,         0,1,0,0, 17,31,               1,0,1, 3);
      vecs[11] = mk(1,0,3,0,                  0,0,0,0,                    0,0,0,0, 17,31,               0,0,0, 3);
      vecs[12] = mk(1,0,3,0,                  0,0,0,0,                    1,0,0,0, 17,31,               0,0,1, 3);
      vecs[13] = mk(0,0,0,0,                  0,0,0,0,                    0,0,1,0, 32'hDEADBEEF,31,     0,0,0, 3);
      // out-of-bounds write (no DM write) and read (zero data)
      vecs[14] = mk(1,1,40,32'h1234,          0,0,0,0,                    1,0,0,0, 32'hDEADBEEF,31,     0,1,1, 40);
      vecs[15] = mk(0,0,0,0,                  1,0,32,0,                   0,0,0,0, 32'hDEADBEEF,31,     0,0,0, 40);
      vecs[16] = mk(0,0,0,0,                  1,0,32,0,                   0,1,0,0, 32'hDEADBEEF,31,     0,1,1, 32);
      vecs[17] = mk(0,0,0,0,                  0,0,0,0,                    0,0,0,1, 32'hDEADBEEF,0,      0,0,0, 32);
      // last in-range word
      vecs[18] = mk(1,0,31,0,                 0,0,0,0,                    1,0,0,0, 32'hDEADBEEF,0,      0,0,1, 31);
      vecs[19] = mk(0,0,0,0,                  0,0,0,0,                    0,0,1,0, 32'h31313131,0,      0,0,0, 31);
      // high address bit set: must not alias to word 15
      vecs[20] = mk(0,0,0,0,                  1,0,32'h8000000F,0,         0,1,0,0, 32'h31313131,0,      0,1,1, 32'h8000000F);
      vecs[21] = mk(0,0,0,0,                  0,0,0,0,                    0,0,0,1, 32'h31313131,0,      0,0,0, 32'h8000000F);
      // p1 raises req while p0 is in SERVE -> served next
      vecs[22] = mk(1,0,16,0,                 0,0,0,0,                    1,0,0,0, 32'h31313131,0,      0,0,1, 16);
      vecs[23] = mk(0,0,0,0,                  1,0,15,0,                   0,0,1,0, 31,0,                0,0,0, 16);
      vecs[24] = mk(0,0,0,0,                  1,0,15,0,                   0,1,0,0, 31,0,                0,0,1, 15);
      vecs[25] = mk(0,0,0,0,                  0,0,0,0,                    0,0,0,1, 31,17,               0,0,0, 15);

      // ---- reset held with both ports requesting ----
      RST_N = 1'b0;
      drive(vecs[0]);
      repeat (2) @(posedge CLK);
      #1;
      check("rst p0_gnt",    32'(bus.p0_gnt),    32'd0);
      check("rst p1_gnt",    32'(bus.p1_gnt),    32'd0);
      check("rst p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
      check("rst p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
      check("rst p0_rdata",  bus.p0_rdata,       32'd0);
      check("rst p1_rdata",  bus.p1_rdata,       32'd0);
      check("rst mem_wr",    32'(bus.mem_wr),    32'd0);
      check("rst mem_addr",  bus.mem_addr,       32'd0);
      check("rst mem_din",   bus.mem_din,        32'd0);
      check("rst err_oob",   32'(bus.err_oob),   32'd0);
      check("rst busy",      32'(bus.busy),      32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      // ---- table ----
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         @(posedge CLK);
         #1;
         check_outputs($sformatf("v%0d", i), vecs[i]);
      end

      // ---- reset in the SERVE cycle of a p0 write to addr 5 ----
      idle_inputs();
      bus.p0_req = 1'b1;  bus.p0_wr = 1'b1;  bus.p0_addr = 32'd5;  bus.p0_din = 32'hAAAA_AAAA;
      @(posedge CLK);
      #1;
      check("t6 p0_gnt",  32'(bus.p0_gnt), 32'd1);
      check("t6 mem_wr",  32'(bus.mem_wr), 32'd1);
      #2;
      RST_N = 1'b0;
      idle_inputs();
      #1;
      check("t6 mem_wr drop",  32'(bus.mem_wr),  32'd0);
      check("t6 gnt drop",     32'(bus.p0_gnt),  32'd0);
      check("t6 busy drop",    32'(bus.busy),    32'd0);
      check("t6 mem_addr rst", bus.mem_addr,     32'd0);
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge CLK);
         #1;
         check($sformatf("t6 post c%0d p0_gnt", c),    32'(bus.p0_gnt),    32'd0);
         check($sformatf("t6 post c%0d p0_rvalid", c), 32'(bus.p0_rvalid), 32'd0);
         check($sformatf("t6 post c%0d busy", c),      32'(bus.busy),      32'd0);
      end
      check("t6 dm5 unchanged", dm[5], 32'h0000_0055);

      // re-issued request after reset: read addr 5
      bus.p0_req = 1'b1;  bus.p0_wr = 1'b0;  bus.p0_addr = 32'd5;
      @(posedge CLK);
      #1;
      check("t6 reissue p0_gnt", 32'(bus.p0_gnt), 32'd1);
      idle_inputs();
      @(posedge CLK);
      #1;
      check("t6 reissue p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
      check("t6 reissue p0_rdata",  bus.p0_rdata,       32'h0000_0055);

      // ---- report ----
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
